// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory with a fixed-latency request/response
// handshake for a simple core. Byte/half/word loads and stores, alignment and
// encoding faults, and a configurable number of wait states.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset (storage is not cleared)
//   mem_read    load request
//   mem_write   store request (wins when both requests are high)
//   funct3      access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   address     byte address; bits above the word index are ignored
//   write_data  store data
//   read_data   registered load result, 0 after stores and faults
//   ready       one-cycle response strobe
//   err         access fault, qualified by ready
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        err
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned ADDR_W = IDX_W + 2;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [2:0]          f3_q, f3_d;
  logic                store_q, store_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic [31:0]         mem_q [DEPTH_WORDS];

  logic                is_idle_c, req_c, wait_done_c, commit_c, acc_err_c, mem_we_c;
  logic [ADDR_W-1:0]   cur_addr_c;
  logic [31:0]         cur_wdata_c;
  logic [2:0]          cur_f3_c;
  logic                cur_store_c;
  logic [IDX_W-1:0]    idx_c;
  logic [1:0]          lane_c;
  logic [31:0]         word_c, load_c, merged_c;
  logic [7:0]          byte_c;
  logic [15:0]         half_c;
  logic                addr_unused_c;

  assign addr_unused_c = ^address[31:ADDR_W];

  // Live inputs while idle (a zero-wait request commits on its accepting edge),
  // latched request otherwise.
  assign is_idle_c   = (state_q == S_IDLE);
  assign req_c       = mem_read | mem_write;
  assign cur_addr_c  = is_idle_c ? address[ADDR_W-1:0] : addr_q;
  assign cur_wdata_c = is_idle_c ? write_data : wdata_q;
  assign cur_f3_c    = is_idle_c ? funct3 : f3_q;
  assign cur_store_c = is_idle_c ? mem_write : store_q;

  assign idx_c       = cur_addr_c[ADDR_W-1:2];
  assign lane_c      = cur_addr_c[1:0];
  assign word_c      = mem_q[idx_c];
  assign wait_done_c = (cnt_q <= CNT_W'(1));

  // Edge that enters RESP: store commits and load data is captured here.
  assign commit_c = (is_idle_c && req_c && (WAIT_STATES == 0)) ||
                    ((state_q == S_WAIT) && wait_done_c);
  assign mem_we_c = commit_c && cur_store_c && !acc_err_c && !reset;

  // Misalignment and illegal-encoding detection.
  always_comb begin
    acc_err_c = 1'b0;
    case (cur_f3_c[1:0])
      2'b01:   acc_err_c = lane_c[0];
      2'b10:   acc_err_c = (lane_c != 2'b00);
      2'b11:   acc_err_c = 1'b1;
      default: acc_err_c = 1'b0;
    endcase
    if (cur_store_c && cur_f3_c[2]) acc_err_c = 1'b1;
    if (!cur_store_c && (cur_f3_c == 3'b110)) acc_err_c = 1'b1;
  end

  // Load lane extraction with sign/zero extension.
  always_comb begin
    byte_c = 8'(word_c >> {lane_c, 3'b000});
    half_c = lane_c[1] ? word_c[31:16] : word_c[15:0];
    load_c = word_c;
    case (cur_f3_c[1:0])
      2'b00:   load_c = cur_f3_c[2] ? {24'h0, byte_c} : {{24{byte_c[7]}}, byte_c};
      2'b01:   load_c = cur_f3_c[2] ? {16'h0, half_c} : {{16{half_c[15]}}, half_c};
      default: load_c = word_c;
    endcase
  end

  // Store merge: untouched lanes keep their old contents.
  always_comb begin
    merged_c = word_c;
    case (cur_f3_c[1:0])
      2'b00:   merged_c[{lane_c, 3'b000} +: 8]     = cur_wdata_c[7:0];
      2'b01:   merged_c[{lane_c[1], 4'b0000} +: 16] = cur_wdata_c[15:0];
      2'b10:   merged_c = cur_wdata_c;
      default: merged_c = word_c;
    endcase
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    store_d = store_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_c) begin
          addr_d  = address[ADDR_W-1:0];
          wdata_d = write_data;
          f3_d    = funct3;
          store_d = mem_write;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        if (wait_done_c) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (commit_c) begin
      ready_d = 1'b1;
      err_d   = acc_err_c;
      rdata_d = (acc_err_c || cur_store_c) ? 32'h0 : load_c;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      store_q <= store_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Storage array; deliberately survives reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[idx_c] <= merged_c;
  end

  assign read_data = rdata_q;
  assign ready     = ready_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (0, 1 and 3 wait states) share the
// request inputs; only the instance under test is out of reset at any time.
module tb_dmem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] address, write_data;
  logic [31:0] rdata_w [3];
  logic [2:0]  ready_w, err_w;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .reset(rst[0]), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .address(address), .write_data(write_data),
    .read_data(rdata_w[0]), .ready(ready_w[0]), .err(err_w[0]));

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1)) u_dut_ws1 (
    .clk(clk), .reset(rst[1]), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .address(address), .write_data(write_data),
    .read_data(rdata_w[1]), .ready(ready_w[1]), .err(err_w[1]));

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3)) u_dut_ws3 (
    .clk(clk), .reset(rst[2]), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .address(address), .write_data(write_data),
    .read_data(rdata_w[2]), .ready(ready_w[2]), .err(err_w[2]));

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic int ws_of(input int sel);
    case (sel)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; drives one request, waits for its response, and
  // compares it against the scoreboard entry pushed here. Returns at a falling edge.
  task automatic do_req(input int sel, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_d,
                        input logic exp_e, input string tag);
    exp_t e;
    int   lat;
    logic got;
    e.data = exp_d;
    e.err  = exp_e;
    e.lat  = ws_of(sel) + 1;
    sb_q.push_back(e);
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    address    = a;
    write_data = wd;
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 50) begin
      lat++;
      @(negedge clk);
      got = ready_w[sel];
      if (!got) @(posedge clk);
    end
    e = sb_q.pop_front();
    chk({tag, "/ready"}, 32'(got), 32'd1);
    chk({tag, "/latency"}, 32'(lat), 32'(e.lat));
    chk({tag, "/data"}, rdata_w[sel], e.data);
    chk({tag, "/err"}, 32'(err_w[sel]), 32'(e.err));
    @(negedge clk);
    chk({tag, "/ready_drop"}, 32'(ready_w[sel]), 32'd0);
  endtask

  initial begin
    logic [5:0] pat;
    int         nready;
    rst        = 3'b111;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'b000;
    address    = 32'h0;
    write_data = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_rdata%0d", i), rdata_w[i], 32'h0);
      chk($sformatf("reset_ready%0d", i), 32'(ready_w[i]), 32'd0);
      chk($sformatf("reset_err%0d", i), 32'(err_w[i]), 32'd0);
    end

    // One wait state; first request on the first edge after reset release.
    rst[1] = 1'b0;
    do_req(1, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw_10");
    do_req(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw_10");
    do_req(1, 1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, "lb_13");
    do_req(1, 1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0, "lbu_13");
    do_req(1, 1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, "lh_12");
    do_req(1, 1'b1, 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, "lhu_10");
    do_req(1, 1'b0, 1'b1, 3'b000, 32'h11, 32'h55, 32'h0, 1'b0, "sb_11");
    do_req(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, "lw_after_sb");
    do_req(1, 1'b1, 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, "lw_misalign");
    do_req(1, 1'b0, 1'b1, 3'b001, 32'h11, 32'hFFFF, 32'h0, 1'b1, "sh_misalign");
    do_req(1, 1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, "ld_f3_011");
    do_req(1, 1'b0, 1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1, "st_f3_100");
    do_req(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, "lw_after_err");
    do_req(1, 1'b0, 1'b1, 3'b001, 32'h12, 32'hA5A5, 32'h0, 1'b0, "sh_12");
    do_req(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5A555EF, 1'b0, "lw_after_sh");
    do_req(1, 1'b1, 1'b0, 3'b000, 32'h11, 32'h0, 32'h00000055, 1'b0, "lb_11");
    do_req(1, 1'b1, 1'b0, 3'b001, 32'h10, 32'h0, 32'h000055EF, 1'b0, "lh_10");
    do_req(1, 1'b1, 1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, "lb_10");
    do_req(1, 1'b0, 1'b1, 3'b010, 32'h400, 32'h12345678, 32'h0, 1'b0, "sw_400");
    do_req(1, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 32'h12345678, 1'b0, "lw_wrap");

    // Request held high through the response is re-accepted after RESP.
    mem_read = 1'b1;
    funct3   = 3'b010;
    address  = 32'h0;
    pat      = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      pat[i] = ready_w[1];
      if (i == 4) mem_read = 1'b0;
    end
    chk("held_req_pattern", 32'(pat), 32'h12);
    chk("held_req_data", rdata_w[1], 32'h12345678);

    // Zero wait states.
    rst[1] = 1'b1;
    rst[0] = 1'b0;
    do_req(0, 1'b0, 1'b1, 3'b010, 32'h8, 32'h01020304, 32'h0, 1'b0, "ws0_sw_8");
    do_req(0, 1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 32'h01020304, 1'b0, "ws0_lw_8");
    do_req(0, 1'b1, 1'b0, 3'b100, 32'h9, 32'h0, 32'h00000003, 1'b0, "ws0_lbu_9");

    // Three wait states; reset during WAIT aborts the store.
    rst[0] = 1'b1;
    rst[2] = 1'b0;
    do_req(2, 1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, "ws3_sw_20");
    do_req(2, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, "ws3_lw_20");
    mem_write  = 1'b1;
    funct3     = 3'b010;
    address    = 32'h20;
    write_data = 32'h1;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst[2] = 1'b1;
    #1;
    chk("abort_rdata_cleared", rdata_w[2], 32'h0);
    chk("abort_ready_low", 32'(ready_w[2]), 32'd0);
    chk("abort_err_low", 32'(err_w[2]), 32'd0);
    nready = 0;
    repeat (3) begin
      @(negedge clk);
      if (ready_w[2]) nready++;
    end
    rst[2] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ready_w[2]) nready++;
    end
    chk("abort_no_ready", 32'(nready), 32'd0);
    do_req(2, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, "ws3_lw_after_abort");
    do_req(2, 1'b1, 1'b1, 3'b010, 32'h24, 32'h0BADF00D, 32'h0, 1'b0, "ws3_rdwr_store");
    do_req(2, 1'b1, 1'b0, 3'b010, 32'h24, 32'h0, 32'h0BADF00D, 1'b0, "ws3_lw_24");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256 (power of two, 4..4096): number of 32-bit storage words.
REQ-002 SHALL have parameter WAIT_STATES, default 1 (0..15): cycles spent in WAIT before a response.
REQ-003 SHALL use one clock; reset is asynchronous and active-high (ports clk, reset).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 mem_read  input  1  load request from core.
REQ-007 mem_write  input  1  store request from core.
REQ-008 funct3  input  3  access size/sign: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
REQ-009 address  input  32  byte address, driven from the core ALU result.
REQ-010 write_data  input  32  store data, driven from the core register-file read port 2.
REQ-011 read_data  output  32  load result, registered, feeds the core memory-data input.
REQ-012 ready  output  1  one-cycle response strobe.
REQ-013 err  output  1  access fault, valid only while ready=1.

Function
REQ-014 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; WAIT is skipped when WAIT_STATES=0.
REQ-015 In IDLE, an edge with mem_read or mem_write high SHALL latch address, funct3, write_data and request type, then enter WAIT (or RESP if WAIT_STATES=0).
REQ-016 mem_read and mem_write both high SHALL be treated as a store.
REQ-017 WAIT SHALL hold for exactly WAIT_STATES cycles via a down-counter loaded at acceptance, then enter RESP.
REQ-018 ready SHALL be 1 for exactly the single cycle the FSM is in RESP; latency from the accepting edge to ready high = WAIT_STATES+1 cycles.
REQ-019 Request inputs SHALL be ignored outside IDLE; a request still high in the cycle after RESP SHALL be accepted as a new request.
REQ-020 Word index SHALL be address[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored (wrap-around).
REQ-021 Loads: byte lanes selected by address[1:0]; 000/001 sign-extend, 100/101 zero-extend, 010 full word.
REQ-022 Stores: 000 writes lane address[1:0] from write_data[7:0]; 001 writes lanes 1:0 or 3:2 from write_data[15:0]; 010 writes all lanes; unwritten lanes SHALL be preserved.
REQ-023 err SHALL be set if a halfword access has address[0]=1, a word access has address[1:0]!=0, a load uses funct3 in {011,110,111}, or a store uses funct3 other than 000/001/010.
REQ-024 On err, memory SHALL be unchanged and read_data SHALL be 0.
REQ-025 Store commit SHALL occur on the clock edge that enters RESP; load data SHALL be captured on that same edge.
REQ-026 After a store response, read_data SHALL be 0.
REQ-027 A load following a store to the same word SHALL return the updated data.

Reset
REQ-028 reset high SHALL immediately force FSM=IDLE, counter=0, ready=0, err=0, read_data=0, regardless of clk.
REQ-029 Storage contents SHALL NOT be cleared by reset.
REQ-030 Reset asserted before the commit edge SHALL abort the request, with no memory write and no ready.
REQ-031 First acceptance SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-032 WAIT_STATES=1: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> ready 2 cycles after each accept; read_data=0xDEADBEEF, err=0.
REQ-033 After REQ-032: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-034 SB 0x11 data 0x55, then LW 0x10 -> 0xDEAD55EF.
REQ-035 LW 0x12 or SH 0x11 -> ready with err=1, read_data=0; a following LW 0x10 returns the unchanged word.
REQ-036 DEPTH_WORDS=256: SW 0x400 data 0x12345678, then LW 0x0 -> 0x12345678 (wrap-around).
REQ-037 WAIT_STATES=3: assert reset during WAIT of SW 0x20 data 0x1 -> ready never pulses; a later LW 0x20 returns the prior contents; mem_read and mem_write held high together -> store performed.
